// File: rtl/aukv_pkg.sv
// Shared decode constants for the aukv ALU decode stage: opcodes, ALU op codes, funct7 forms.
package aukv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_OR  = 3'd2,
    ALU_AND = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  // alt selects SUB on funct3 000 and SRA on funct3 101; callers only pass alt for legal forms.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      3'b100:  op = ALU_XOR;
      3'b001:  op = ALU_SLL;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/aukv_imm_gen.sv
// Combinational I/S/U immediate extraction with sign extension for the RV32I decode stage.
module aukv_imm_gen (
  input  logic [31:7] i_instr_hi,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_u
);

  assign o_imm_i = {{20{i_instr_hi[31]}}, i_instr_hi[31:20]};
  assign o_imm_s = {{20{i_instr_hi[31]}}, i_instr_hi[31:25], i_instr_hi[11:7]};
  assign o_imm_u = {i_instr_hi[31:12], 12'd0};

endmodule

// File: rtl/aukv_alu_decode.sv
// RV32I decode into ALU op/operands, registered in one valid/ready slot.
// Optional macro AUKV_DEC_ILLEGAL_EN enables the registered o_illegal flag.
module aukv_alu_decode
  import aukv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [2:0]      o_alu_op,
  output logic [XLEN-1:0] o_op_a,
  output logic [XLEN-1:0] o_op_b,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_we,
  output logic [XLEN-1:0] o_pc,
  output logic            o_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       f3_shift;
  logic       f7_ok;

  assign opcode   = i_instr[6:0];
  assign rd       = i_instr[11:7];
  assign funct3   = i_instr[14:12];
  assign funct7   = i_instr[31:25];
  assign f3_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign f7_ok    = (funct7 == F7_BASE) || (funct7 == F7_ALT);

  logic [31:0] imm_i, imm_s, imm_u;

  aukv_imm_gen u_imm_gen (
    .i_instr_hi (i_instr[31:7]),
    .o_imm_i    (imm_i),
    .o_imm_s    (imm_s),
    .o_imm_u    (imm_u)
  );

  logic unsup;

  always_comb begin
    unsup = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) unsup = 1'b1;
        if (!f7_ok) unsup = 1'b1;
        if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101) unsup = 1'b1;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) unsup = 1'b1;
        // Only shifts carry a funct7 field; other OP-IMM forms use those bits as immediate.
        if (f3_shift && !f7_ok) unsup = 1'b1;
        if (funct3 == 3'b001 && funct7 == F7_ALT) unsup = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE: unsup = 1'b0;
      default: unsup = 1'b1;
    endcase
  end

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_wb;

  always_comb begin
    dec_op = ALU_ADD;
    dec_a  = '0;
    dec_b  = '0;
    dec_wb = 1'b0;
    if (!unsup) begin
      case (opcode)
        OPC_OP: begin
          dec_a  = i_rs1_data;
          // The ALU shifts by the whole operand, so the shift amount is masked here.
          dec_b  = f3_shift ? {{(XLEN-5){1'b0}}, i_rs2_data[4:0]} : i_rs2_data;
          dec_op = f3_to_op(funct3, funct7[5]);
          dec_wb = 1'b1;
        end
        OPC_OPIMM: begin
          dec_a  = i_rs1_data;
          dec_b  = f3_shift ? {{(XLEN-5){1'b0}}, i_instr[24:20]} : imm_i;
          dec_op = f3_to_op(funct3, f3_shift & i_instr[30]);
          dec_wb = 1'b1;
        end
        OPC_LUI: begin
          dec_b  = imm_u;
          dec_wb = 1'b1;
        end
        OPC_AUIPC: begin
          dec_a  = i_pc;
          dec_b  = imm_u;
          dec_wb = 1'b1;
        end
        OPC_LOAD: begin
          dec_a  = i_rs1_data;
          dec_b  = imm_i;
          dec_wb = 1'b1;
        end
        OPC_STORE: begin
          dec_a  = i_rs1_data;
          dec_b  = imm_s;
        end
        default: ;
      endcase
    end
  end

  logic            capture;
  logic            valid_d, valid_q;
  logic [2:0]      op_d, op_q;
  logic [XLEN-1:0] a_d, a_q, b_d, b_q, pc_d, pc_q;
  logic [4:0]      rd_d, rd_q;
  logic            we_d, we_q;

  assign o_ready = ~valid_q | i_ready;
  assign capture = i_valid & o_ready;

  always_comb begin
    valid_d = valid_q;
    if (i_flush)      valid_d = 1'b0;
    else if (capture) valid_d = 1'b1;
    else if (i_ready) valid_d = 1'b0;
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    rd_d = rd_q;
    we_d = we_q;
    pc_d = pc_q;
    if (capture) begin
      op_d = dec_op;
      a_d  = dec_a;
      b_d  = dec_b;
      rd_d = rd;
      we_d = dec_wb & (rd != 5'd0);
      pc_d = i_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      pc_q    <= RESET_PC[XLEN-1:0];
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      pc_q    <= pc_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_alu_op  = op_q;
  assign o_op_a    = a_q;
  assign o_op_b    = b_q;
  assign o_rd_addr = rd_q;
  assign o_rd_we   = we_q;
  assign o_pc      = pc_q;

`ifdef AUKV_DEC_ILLEGAL_EN
  logic ill_d, ill_q;

  always_comb begin
    ill_d = ill_q;
    if (capture) ill_d = unsup;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ill_q <= 1'b0;
    else         ill_q <= ill_d;
  end

  assign o_illegal = ill_q;
`else
  assign o_illegal = 1'b0;
`endif

endmodule
